sync_fifo_ctrl: RTL and testbench
=================================

Name: sync_fifo_ctrl

Overview:
Pointer and flag controller for the synchronous FIFO; sits directly upstream of the dual-port RAM.
- Accepts push/pop requests.
- Drives the RAM write/read enables and addresses.
- Tracks occupancy and produces full/empty/almost flags.
- Produces a read-data-valid strobe aligned with the RAM's one-cycle registered read output.

Parameters:
- ADDR_WIDTH, 9: RAM address width; depth = 2**ADDR_WIDTH.
- AF_THRESH, 2**ADDR_WIDTH-4: almost_full asserted when count >= AF_THRESH.
- AE_THRESH, 4: almost_empty asserted when count <= AE_THRESH.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- wr_en  in  1  push request.
- rd_en  in  1  pop request.
- err_clr  in  1  clears sticky error flags (used only with the optional feature).
- ram_we  out  1  to RAM Write_EN.
- ram_waddr  out  ADDR_WIDTH  to RAM write_addr.
- ram_re  out  1  to RAM Read_EN.
- ram_raddr  out  ADDR_WIDTH  to RAM read_addr.
- rd_valid  out  1  RAM DataOut holds popped word this cycle.
- full  out  1  count == depth.
- empty  out  1  count == 0.
- almost_full  out  1  count >= AF_THRESH.
- almost_empty  out  1  count <= AE_THRESH.
- count  out  ADDR_WIDTH+1  current occupancy, 0..depth.
- overflow  out  1  sticky: push attempted while full.
- underflow  out  1  sticky: pop attempted while empty.

Behaviour:
- Reset is asynchronous and active-low, rst_n; clock is clk.
- Reset values: wr_ptr=0, rd_ptr=0, rd_valid=0, overflow=0, underflow=0. Hence count=0, empty=1, full=0, almost_empty=1, almost_full=0.
- Pointers: wr_ptr and rd_ptr are ADDR_WIDTH+1 bits. The MSB is the wrap bit. Each pointer increments by 1 on an accepted operation and wraps naturally modulo 2**(ADDR_WIDTH+1).
- Accept rules:
  - push_ok = wr_en & ~full.
  - pop_ok = rd_en & ~empty.
  - Flags are evaluated from the pre-edge state. A pop does not free space for a same-cycle push, and a push does not enable a same-cycle pop.
- RAM drive is combinational from registered pointers:
  - ram_we = push_ok, ram_waddr = wr_ptr[ADDR_WIDTH-1:0].
  - ram_re = pop_ok, ram_raddr = rd_ptr[ADDR_WIDTH-1:0].
- Read latency: rd_valid is registered and equals pop_ok delayed one cycle, coincident with the RAM's registered DataOut. Back-to-back pops give continuous rd_valid.
- count = wr_ptr - rd_ptr (ADDR_WIDTH+1-bit modular subtract).
- full = (MSBs differ) & (low bits equal). empty = (pointers equal).
- All flags are combinational from registered pointers, so they are glitch-free relative to clk and updated the cycle after the accepted operation.
- Simultaneous push and pop, neither blocked: both pointers advance, count unchanged.
  - At count=1 the RAM read and write target different addresses.
  - When full, push is refused while the pop proceeds.
  - When empty, pop is refused while the push proceeds.
- Wrap-around: after 2**ADDR_WIDTH pushes the low address returns to 0 and the wrap bit toggles. Flags remain correct across any number of wraps.
- Reset mid-operation: all state clears immediately, regardless of clk. An in-flight rd_valid is dropped. Ignore requests while rst_n is low.

Optional Feature:
- Macro: SYNC_FIFO_CTRL_ERR_EN.
- Defined:
  - overflow sets on wr_en & full.
  - underflow sets on rd_en & empty.
  - Both stay set until an err_clr cycle, which clears them on the next edge. A set event in the same cycle as err_clr wins, so the flag stays 1.
- Undefined: overflow and underflow are tied 0, err_clr is ignored, and no error registers exist. Ports remain present in both builds.

Decomposition:
- Package sync_fifo_pkg:
  - function/localparam for DEPTH = 2**ADDR_WIDTH.
  - default threshold constants.
  - typedef for the ADDR_WIDTH+1 pointer type.
- One sub-module, fifo_ptr: pointer register with enable and wrap bit, asynchronous reset. Instantiated twice, for write and read.
- Flag/count logic stays in the top.

Test Plan:
All scenarios use ADDR_WIDTH=3 (depth 8), AF_THRESH=6, AE_THRESH=1, feature enabled.
1. Reset, then idle → empty=1, full=0, count=0, almost_empty=1, rd_valid=0, ram_we=ram_re=0.
2. Push 8 words (wr_en for 8 cycles) → ram_waddr 0..7. almost_full=1 at count 6. full=1 after 8th push. 9th push gives ram_we=0 and overflow=1. err_clr then clears overflow.
3. From full, pop 8 → ram_raddr 0..7. rd_valid high the cycle after each ram_re. empty=1 at end. Extra pop gives ram_re=0 and underflow=1.
4. Hold wr_en=rd_en=1 for 20 cycles starting at count=3 → count stays 3. Pointers wrap twice, with low address passing 7→0. Flags unchanged.
5. At empty, wr_en=rd_en=1 for one cycle → push only, count=1, ram_re=0. At full, same stimulus → pop only, count=7, ram_we=0.
6. Assert rst_n=0 mid-burst between clock edges, at count=5 with rd_valid=1 → all outputs take reset values immediately, with no clk edge needed.

Source files
------------

// File: rtl/sync_fifo_pkg.sv
// sync_fifo_pkg: shared sizing helpers and default thresholds for the FIFO controller.
package sync_fifo_pkg;
  localparam int DEF_ADDR_WIDTH = 9;
  localparam int DEF_AF_MARGIN = 4;
  localparam int DEF_AE_THRESH = 4;
  typedef logic [DEF_ADDR_WIDTH:0] def_ptr_t;
  function automatic int fifo_depth(input int aw);
    return 1 << aw;
  endfunction
endpackage

// File: rtl/sync_fifo_ctrl_fifo_ptr.sv
// fifo_ptr: ADDR_WIDTH+1 bit pointer with wrap bit, advancing by one when en is high.
module fifo_ptr #(
  parameter int ADDR_WIDTH = 9
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  output logic [ADDR_WIDTH:0]   ptr
);
  logic [ADDR_WIDTH:0] ptr_q, ptr_d;
  always_comb ptr_d = en ? ptr_q + 1'b1 : ptr_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) ptr_q <= '0;
    else ptr_q <= ptr_d;
  assign ptr = ptr_q;
endmodule

// File: rtl/sync_fifo_ctrl.sv
// sync_fifo_ctrl: pointer/flag controller driving a dual-port RAM with one-cycle registered read.
// Define SYNC_FIFO_CTRL_ERR_EN to build the sticky overflow/underflow registers.
module sync_fifo_ctrl
  import sync_fifo_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int AF_THRESH = fifo_depth(ADDR_WIDTH) - DEF_AF_MARGIN,
  parameter int AE_THRESH = DEF_AE_THRESH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic                  rd_en,
  input  logic                  err_clr,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_waddr,
  output logic                  ram_re,
  output logic [ADDR_WIDTH-1:0] ram_raddr,
  output logic                  rd_valid,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow
);
  localparam logic [ADDR_WIDTH:0] AF_C = (ADDR_WIDTH+1)'(AF_THRESH);
  localparam logic [ADDR_WIDTH:0] AE_C = (ADDR_WIDTH+1)'(AE_THRESH);
  logic [ADDR_WIDTH:0] wr_ptr, rd_ptr;
  logic push_ok, pop_ok, rd_valid_q, rd_valid_d;
  // Requests are gated by rst_n so nothing reaches the RAM while reset is held.
  always_comb begin
    full = (wr_ptr[ADDR_WIDTH] != rd_ptr[ADDR_WIDTH]) &&
           (wr_ptr[ADDR_WIDTH-1:0] == rd_ptr[ADDR_WIDTH-1:0]);
    empty = wr_ptr == rd_ptr;
    count = wr_ptr - rd_ptr;
    almost_full = count >= AF_C;
    almost_empty = count <= AE_C;
    push_ok = rst_n & wr_en & ~full;
    pop_ok = rst_n & rd_en & ~empty;
    rd_valid_d = pop_ok;
  end
  fifo_ptr #(.ADDR_WIDTH(ADDR_WIDTH)) u_wr_ptr (
    .clk(clk), .rst_n(rst_n), .en(push_ok), .ptr(wr_ptr)
  );
  fifo_ptr #(.ADDR_WIDTH(ADDR_WIDTH)) u_rd_ptr (
    .clk(clk), .rst_n(rst_n), .en(pop_ok), .ptr(rd_ptr)
  );
  assign ram_we = push_ok;
  assign ram_waddr = wr_ptr[ADDR_WIDTH-1:0];
  assign ram_re = pop_ok;
  assign ram_raddr = rd_ptr[ADDR_WIDTH-1:0];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) rd_valid_q <= 1'b0;
    else rd_valid_q <= rd_valid_d;
  assign rd_valid = rd_valid_q;
`ifdef SYNC_FIFO_CTRL_ERR_EN
  logic ovf_q, ovf_d, udf_q, udf_d;
  // A new error event beats a simultaneous clear.
  always_comb begin
    ovf_d = (wr_en & full) | (ovf_q & ~err_clr);
    udf_d = (rd_en & empty) | (udf_q & ~err_clr);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
      udf_q <= udf_d;
    end
  assign overflow = ovf_q;
  assign underflow = udf_q;
`else
  logic unused_err_clr;
  assign unused_err_clr = err_clr;
  assign overflow = 1'b0;
  assign underflow = 1'b0;
`endif
endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// tb_sync_fifo_ctrl: directed self-checking bench for sync_fifo_ctrl at depth 8.
module tb_sync_fifo_ctrl;
  localparam int AW = 3;
`ifdef SYNC_FIFO_CTRL_ERR_EN
  localparam logic ERR = 1'b1;
`else
  localparam logic ERR = 1'b0;
`endif
  logic clk = 1'b0, rst_n = 1'b0, wr_en = 1'b0, rd_en = 1'b0, err_clr = 1'b0;
  logic ram_we, ram_re, rd_valid, full, empty, almost_full, almost_empty, overflow, underflow;
  logic [AW-1:0] ram_waddr, ram_raddr;
  logic [AW:0] count;
  int tests = 0, fails = 0;

  sync_fifo_ctrl #(.ADDR_WIDTH(AW), .AF_THRESH(6), .AE_THRESH(1)) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .rd_en(rd_en), .err_clr(err_clr),
    .ram_we(ram_we), .ram_waddr(ram_waddr), .ram_re(ram_re), .ram_raddr(ram_raddr),
    .rd_valid(rd_valid), .full(full), .empty(empty), .almost_full(almost_full),
    .almost_empty(almost_empty), .count(count), .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, ".empty"}, empty, 1);
    chk({tag, ".full"}, full, 0);
    chk({tag, ".count"}, count, 0);
    chk({tag, ".ae"}, almost_empty, 1);
    chk({tag, ".af"}, almost_full, 0);
    chk({tag, ".rd_valid"}, rd_valid, 0);
    chk({tag, ".ram_we"}, ram_we, 0);
    chk({tag, ".ram_re"}, ram_re, 0);
    chk({tag, ".overflow"}, overflow, 0);
    chk({tag, ".underflow"}, underflow, 0);
  endtask

  initial begin
    #12 rst_n = 1'b1;
    tick();
    #1 chk_reset_state("reset");

    for (int i = 0; i < 8; i++) begin
      wr_en = 1'b1;
      #1;
      chk("fill.we", ram_we, 1);
      chk("fill.waddr", ram_waddr, i);
      chk("fill.count", count, i);
      chk("fill.af", almost_full, i >= 6);
      chk("fill.full", full, 0);
      tick();
    end
    #1;
    chk("fill.count8", count, 8);
    chk("fill.full8", full, 1);
    chk("fill.ae8", almost_empty, 0);
    chk("ovf.we", ram_we, 0);
    tick();
    wr_en = 1'b0;
    #1;
    chk("ovf.set", overflow, ERR);
    chk("ovf.count", count, 8);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    #1 chk("ovf.clr", overflow, 0);

    for (int i = 0; i < 8; i++) begin
      rd_en = 1'b1;
      #1;
      chk("drain.re", ram_re, 1);
      chk("drain.raddr", ram_raddr, i);
      chk("drain.rd_valid", rd_valid, i > 0);
      chk("drain.count", count, 8 - i);
      tick();
    end
    rd_en = 1'b0;
    #1;
    chk("drain.last_valid", rd_valid, 1);
    chk("drain.empty", empty, 1);
    chk("drain.count0", count, 0);
    rd_en = 1'b1;
    #1 chk("udf.re", ram_re, 0);
    tick();
    rd_en = 1'b0;
    #1;
    chk("udf.set", underflow, ERR);
    chk("udf.rd_valid", rd_valid, 0);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    #1 chk("udf.clr", underflow, 0);

    wr_en = 1'b1;
    repeat (3) tick();
    wr_en = 1'b0;
    for (int i = 0; i < 20; i++) begin
      wr_en = 1'b1;
      rd_en = 1'b1;
      #1;
      chk("stream.count", count, 3);
      chk("stream.waddr", ram_waddr, (3 + i) % 8);
      chk("stream.raddr", ram_raddr, i % 8);
      chk("stream.we_re", {ram_we, ram_re}, 2'b11);
      chk("stream.flags", {full, empty, almost_full, almost_empty}, 4'b0000);
      tick();
    end
    wr_en = 1'b0;
    rd_en = 1'b0;
    #1 chk("stream.count_end", count, 3);

    rd_en = 1'b1;
    repeat (3) tick();
    rd_en = 1'b0;
    #1 chk("simul_empty.pre", empty, 1);
    wr_en = 1'b1;
    rd_en = 1'b1;
    #1;
    chk("simul_empty.we", ram_we, 1);
    chk("simul_empty.re", ram_re, 0);
    tick();
    wr_en = 1'b0;
    rd_en = 1'b0;
    #1;
    chk("simul_empty.count", count, 1);
    chk("simul_empty.udf", underflow, ERR);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    wr_en = 1'b1;
    repeat (7) tick();
    wr_en = 1'b0;
    #1 chk("simul_full.pre", full, 1);
    wr_en = 1'b1;
    rd_en = 1'b1;
    #1;
    chk("simul_full.we", ram_we, 0);
    chk("simul_full.re", ram_re, 1);
    tick();
    wr_en = 1'b0;
    rd_en = 1'b0;
    #1;
    chk("simul_full.count", count, 7);
    chk("simul_full.ovf", overflow, ERR);

    rd_en = 1'b1;
    repeat (2) tick();
    wr_en = 1'b1;
    #1;
    chk("rst.pre_count", count, 5);
    chk("rst.pre_valid", rd_valid, 1);
    rst_n = 1'b0;
    #1 chk_reset_state("async_rst");
    tick();
    #1 chk("rst.held_count", count, 0);
    wr_en = 1'b0;
    rd_en = 1'b0;
    #2 rst_n = 1'b1;
    tick();
    #1 chk_reset_state("post_rst");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
